fetch_line_buffer: RTL
======================

Name: fetch_line_buffer

Overview:
- Parametrised instruction buffer between the I-cache and decode.
- Accepts whole I-cache lines (fetch PC plus LINE_INSTR instructions) into a DEPTH-entry line FIFO.
- Emits one instruction per cycle with its PC over a valid/ready handshake, starting at the slot addressed by the fetch PC.
- Supports frontend flush and backpressure on both sides.

Parameters:
- XLEN, 64, PC width.
- ILEN, 32, instruction width.
- LINE_INSTR, 16, instructions per line; power of two, >= 2.
- DEPTH, 2, line FIFO entries; >= 1.
- NOP, 'h13, value driven on instr_o when invalid.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; drops all buffered lines.
- line_valid_i  in  1  line input valid.
- line_ready_o  out  1  line input ready.
- line_pc_i  in  XLEN  fetch PC of the line.
- line_i  in  LINE_INSTR*ILEN  line data; slot s is line_i[s*ILEN +: ILEN].
- instr_valid_o  out  1  instruction output valid.
- instr_ready_i  in  1  decode ready.
- instr_o  out  ILEN  instruction.
- instr_pc_o  out  XLEN  instruction PC.
- line_end_o  out  1  current instruction is the last slot of its line.
- count_o  out  $clog2(DEPTH+1)  buffered line count, including a partially consumed head.

Behaviour:
- Reset is asynchronous, rst_n_i low. Reset values:
  - FIFO empty; count_o=0; read slot=0.
  - instr_valid_o=0; line_ready_o=1; instr_o=NOP; instr_pc_o=0; line_end_o=0.
- Let O=$clog2(ILEN/8) and L=$clog2(LINE_INSTR).
- On push, store:
  - base = line_pc_i with bits [O+L-1:0] cleared;
  - start slot = line_pc_i[O+L-1:O];
  - the line data.
- PC bits [O-1:0] are ignored.
- Push occurs when line_valid_i && line_ready_o && !flush_i.
- line_ready_o = (count_o < DEPTH). It is registered-state only; there is no combinational path from instr_ready_i. A full FIFO does not accept a line even in the cycle the head pops.
- Latency: a line pushed at edge N into an empty buffer gives instr_valid_o=1 after edge N. Data is read combinationally from storage; there is no same-cycle bypass.
- When the head is valid, the outputs are:
  - instr_valid_o=1;
  - instr_o = head data slot r;
  - instr_pc_o = base + r*(ILEN/8);
  - line_end_o = (r == LINE_INSTR-1).
- Here r is the read slot. It is loaded with the start slot when a line becomes head.
- Transfer occurs when instr_valid_o && instr_ready_i.
  - If r < LINE_INSTR-1, r increments.
  - If r == LINE_INSTR-1, the head pops and r loads the next entry's start slot, or 0 if the FIFO is empty.
- Stall: while instr_valid_o && !instr_ready_i, instr_o, instr_pc_o and line_end_o hold stable.
- Simultaneous push and pop in one cycle: count_o is unchanged. Pointers wrap modulo DEPTH.
- When the output is invalid: instr_o=NOP, instr_pc_o=0, line_end_o=0.
- flush_i high at an edge:
  - FIFO emptied, count_o=0, r=0;
  - a concurrent push is discarded, and so is a concurrent transfer;
  - instr_valid_o=0 after that edge;
  - line_ready_o=1 after that edge.
- Flush has priority over push and pop.
- Reset mid-operation discards all contents immediately (asynchronous).
- PC arithmetic is XLEN-bit; base + offset never carries out of the line.

Test Plan:
1. Reset check: assert rst_n_i=0 mid-stream with 2 lines buffered -> immediately instr_valid_o=0, count_o=0, instr_o='h13, line_ready_o=1.
2. Full line from slot 0: push line_pc_i=0x1000, slot s holds 0xA000_0000+s, instr_ready_i=1 -> 16 consecutive transfers.
   - PCs 0x1000..0x103C, instr_o 0xA000_0000..0xA000_000F.
   - line_end_o=1 only at 0x103C; count_o returns to 0.
3. Mid-line start: push line_pc_i=0x103A.
   - Base is 0x1000; bits [1:0] are ignored, giving slot 14.
   - Exactly 2 transfers: 0x1038 (slot 14 data), then 0x103C with line_end_o=1.
4. Backpressure and full:
   - DEPTH=2; push 3 lines with instr_ready_i=0 -> the third line sees line_ready_o=0 and count_o=2; outputs stay constant at the first line's first slot.
   - Release ready -> the third line is accepted only after the first line pops fully.
5. Flush mid-line: flush_i=1 after 5 transfers of line 0x2000 while line_valid_i=1 with 0x3000.
   - The 0x3000 line is not stored; instr_valid_o=0 next cycle; count_o=0.
   - A following push of 0x4004 yields first PC 0x4004.
6. Back-to-back lines: push 0x1030 then 0x2000 with instr_ready_i=1.
   - Output PCs 0x1030..0x103C, then 0x2000 in the very next cycle with no bubble.

Source files
------------

// File: rtl/fetch_line_buffer.sv
// Instruction line buffer between the I-cache and decode: queues whole cache lines
// and emits one instruction per cycle, starting at the slot addressed by the fetch PC.
module fetch_line_buffer #(
  parameter int unsigned     XLEN       = 64,
  parameter int unsigned     ILEN       = 32,
  parameter int unsigned     LINE_INSTR = 16,
  parameter int unsigned     DEPTH      = 2,
  parameter logic [ILEN-1:0] NOP        = 'h13
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         flush_i,
  input  logic                         line_valid_i,
  output logic                         line_ready_o,
  input  logic [XLEN-1:0]              line_pc_i,
  input  logic [LINE_INSTR*ILEN-1:0]   line_i,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  output logic [ILEN-1:0]              instr_o,
  output logic [XLEN-1:0]              instr_pc_o,
  output logic                         line_end_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned O  = $clog2(ILEN/8);
  localparam int unsigned L  = $clog2(LINE_INSTR);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] base_q  [DEPTH];
  logic [XLEN-1:0] base_d  [DEPTH];
  logic [L-1:0]    start_q [DEPTH];
  logic [L-1:0]    start_d [DEPTH];
  logic [ILEN-1:0] data_q  [DEPTH][LINE_INSTR];
  logic [ILEN-1:0] data_d  [DEPTH][LINE_INSTR];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_next, rd_next;
  logic [CW-1:0]   count_q, count_d;
  logic [L-1:0]    slot_q, slot_d;

  logic            head_valid, push, xfer, pop;
  logic [L-1:0]    push_start;
  logic [XLEN-1:0] push_base;
  logic            unused_pc_lsb;

  // PC bits below instruction alignment carry no information and are ignored.
  assign unused_pc_lsb = ^line_pc_i;

  assign head_valid   = (count_q != '0);
  assign line_ready_o = (count_q < CW'(DEPTH));
  assign push         = line_valid_i && line_ready_o && !flush_i;
  assign xfer         = head_valid && instr_ready_i;
  assign pop          = xfer && (slot_q == '1) && !flush_i;
  assign push_start   = line_pc_i[O+L-1:O];
  assign push_base    = {line_pc_i[XLEN-1:O+L], {(O+L){1'b0}}};
  assign wr_next      = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
  assign rd_next      = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
  assign count_o      = count_q;

  always_comb begin
    base_d   = base_q;
    start_d  = start_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    slot_d   = slot_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      slot_d   = '0;
    end else begin
      if (push) begin
        base_d[wr_ptr_q]  = push_base;
        start_d[wr_ptr_q] = push_start;
        for (int unsigned s = 0; s < LINE_INSTR; s++) begin
          data_d[wr_ptr_q][s] = line_i[s*ILEN +: ILEN];
        end
        wr_ptr_d = wr_next;
      end
      if (pop) begin
        rd_ptr_d = rd_next;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // The next head is either an older queued line or the line arriving this cycle.
      if (pop) begin
        if (count_q > CW'(1)) begin
          slot_d = start_q[rd_next];
        end else if (push) begin
          slot_d = push_start;
        end else begin
          slot_d = '0;
        end
      end else if (xfer) begin
        slot_d = slot_q + 1'b1;
      end else if (push && !head_valid) begin
        slot_d = push_start;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      slot_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      slot_q   <= slot_d;
    end
  end

  // Line storage is only observed while counted as valid, so it needs no reset.
  always_ff @(posedge clk_i) begin
    base_q  <= base_d;
    start_q <= start_d;
    data_q  <= data_d;
  end

  always_comb begin
    instr_valid_o = head_valid;
    instr_o       = NOP;
    instr_pc_o    = '0;
    line_end_o    = 1'b0;
    if (head_valid) begin
      instr_o    = data_q[rd_ptr_q][slot_q];
      instr_pc_o = base_q[rd_ptr_q] + (XLEN'(slot_q) << O);
      line_end_o = (slot_q == '1);
    end
  end

endmodule
